// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: start/stop/clear session controller driving a bank of WIDTH
// toggle cells that together form a modulo-M up/down counter.
//
// The cells hold all count state. The controller only computes their T
// inputs, always as t_vec = count ^ next_count.
//
// Optional build macro TFF_ONESHOT_EN: the session ends after exactly M
// steps. The controller goes to DONE on the terminal count instead of
// wrapping. Without the macro the counter free-runs until stop.

module tff_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             up,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             dir_q;       // latched direction: 1 = up
  logic [WIDTH-1:0] mm1_q;       // latched M-1 (mod_val 0 gives all ones)
  logic [WIDTH-1:0] next_count;  // value the cells must hold after this edge
  logic [WIDTH-1:0] last;        // count value that precedes a wrap

  // M-1 computed from the live inputs. mod_val==0 means M = 2^WIDTH, and the
  // modular subtraction produces all ones in that case.
  logic [WIDTH-1:0] live_mm1;
  assign live_mm1 = mod_val - WIDTH'(1);

  assign last = dir_q ? mm1_q : '0;

  // Toggle cell bank: each cell flips where its T input is high.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples pre-edge values no matter how the blocks are ordered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count ^ t_vec;
  end

  // Controller state register. Direction and modulus are captured on start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b1;
      mm1_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        dir_q <= up;
        mm1_q <= live_mm1;
      end
    end
  end

  // Next-state logic, next cell value, and session outputs.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case
    // can leave one unassigned and infer a latch.
    state_d    = state_q;
    next_count = count;
    tc         = 1'b0;
    done       = 1'b0;
    busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        // start wins over stop. stop has no effect here.
        if (start) begin
          next_count = up ? '0 : live_mm1;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        tc = (count == last);
        if (stop) begin
          // stop overrides the count step, including the wrap step.
          state_d = S_CLEAR;
`ifdef TFF_ONESHOT_EN
        end else if (tc) begin
          // Up direction wraps the cells to 0. Down direction is already
          // at 0, so the cells stay there.
          next_count = '0;
          state_d    = S_DONE;
`endif
        end else if (dir_q) begin
          next_count = (count == mm1_q) ? '0 : count + WIDTH'(1);
        end else begin
          next_count = (count == '0) ? mm1_q : count - WIDTH'(1);
        end
      end

      S_CLEAR: begin
        next_count = '0;
        state_d    = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // T inputs are always exactly the bits that must change.
  assign t_vec = count ^ next_count;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Testbench for tff_count_ctrl.
// A reference model computes the expected outputs for every cycle with
// modular arithmetic and pushes them into a queue. A separate monitor pops
// those entries and compares them with the DUT outputs away from the edge.

module tb_tff_count_ctrl;

  localparam int WIDTH = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_CLEAR = 2;
  localparam int PH_DONE  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             up = 1'b1;
  logic [WIDTH-1:0] mod_val = '0;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] t_vec;
  logic             busy;
  logic             tc;
  logic             done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] t_vec;
    logic             busy;
    logic             tc;
    logic             done;
  } exp_t;

  exp_t exp_q[$];

  tff_count_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .up     (up),
    .mod_val(mod_val),
    .count  (count),
    .t_vec  (t_vec),
    .busy   (busy),
    .tc     (tc),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_count = 0;
  int m_ph    = PH_IDLE;
  int m_mod   = 1 << WIDTH;
  int m_dir   = 1;
  int n_count = 0;
  int n_ph    = PH_IDLE;

  // Once per cycle, with inputs stable: predict this cycle's outputs and the
  // model's state after the coming edge.
  always @(negedge clk) begin
    exp_t e;
    int   nxt;
    int   last;
    e.tc   = 1'b0;
    e.done = 1'b0;
    nxt    = m_count;
    n_ph   = m_ph;
    if (rst) begin
      m_count = 0;
      m_ph    = PH_IDLE;
      nxt     = 0;
      n_ph    = PH_IDLE;
    end else begin
      case (m_ph)
        PH_IDLE: if (start) begin
          m_mod = (mod_val == 0) ? (1 << WIDTH) : int'(mod_val);
          m_dir = int'(up);
          nxt   = m_dir ? 0 : m_mod - 1;
          n_ph  = PH_RUN;
        end
        PH_RUN: begin
          last = m_dir ? m_mod - 1 : 0;
          e.tc = (m_count == last);
          if (stop) begin
            n_ph = PH_CLEAR;
`ifdef TFF_ONESHOT_EN
          end else if (e.tc) begin
            nxt  = 0;
            n_ph = PH_DONE;
`endif
          end else begin
            nxt = m_dir ? (m_count + 1) % m_mod : (m_count + m_mod - 1) % m_mod;
          end
        end
        PH_CLEAR: begin
          nxt  = 0;
          n_ph = PH_DONE;
        end
        default: begin
          e.done = 1'b1;
          n_ph   = PH_IDLE;
        end
      endcase
    end
    e.count = WIDTH'(m_count);
    e.t_vec = WIDTH'((m_count ^ nxt) & MASK);
    e.busy  = (m_ph != PH_IDLE);
    n_count = nxt;
    exp_q.push_back(e);
  end

  always @(posedge clk) begin
    m_count <= n_count;
    m_ph    <= n_ph;
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("queue_underflow", 0, 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("count", int'(count), int'(e.count));
        check("t_vec", int'(t_vec), int'(e.t_vec));
        check("busy",  int'(busy),  int'(e.busy));
        check("tc",    int'(tc),    int'(e.tc));
        check("done",  int'(done),  int'(e.done));
      end
    end
  end

  // ---------------- stimulus ----------------
  // One session: start pulse, run_cycles-1 cycles of junk on ignored inputs,
  // a stop pulse, then a few idle cycles. The stop edge sees the count value
  // (run_cycles-1) mod M in free-run mode.
  task automatic session(input logic [WIDTH-1:0] mv, input logic u, input int run_cycles);
    @(posedge clk); #1;
    start = 1'b1; mod_val = mv; up = u;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (run_cycles - 1) begin
      @(posedge clk); #1;
      start   = ($urandom_range(0, 3) == 0);
      mod_val = WIDTH'($urandom);
      up      = 1'($urandom);
    end
    start = 1'b0;
    stop  = 1'b1;
    @(posedge clk); #1;
    stop = 1'($urandom);
    @(posedge clk); #1;
    stop = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int mv;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // start and stop together in IDLE: start wins.
    #1;
    start = 1'b1; stop = 1'b1; mod_val = 4'd4; up = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    repeat (6) @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    repeat (3) @(posedge clk);

    session(4'd10, 1'b1, 25);  // up, free-run wraps 9 -> 0
    session(4'd6,  1'b0, 15);  // down from 5
    session(4'd0,  1'b1, 8);   // stop at count 7
    session(4'd10, 1'b1, 10);  // stop together with tc at count 9
    session(4'd1,  1'b1, 5);   // M == 1, up
    session(4'd1,  1'b0, 4);   // M == 1, down
    session(4'd0,  1'b1, 20);  // wraps 15 -> 0
    session(4'd0,  1'b0, 18);
    session(4'd3,  1'b1, 8);
    session(4'd3,  1'b0, 8);

    for (int i = 0; i < 20; i++) begin
      mv = $urandom_range(0, MASK);
      session(WIDTH'(mv), 1'($urandom), $urandom_range(1, 40));
    end

    // Asynchronous reset at count 5 in the middle of a session.
    @(posedge clk); #1;
    start = 1'b1; mod_val = 4'd10; up = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_busy",  int'(busy),  0);
    check("rst_tc",    int'(tc),    0);
    check("rst_done",  int'(done),  0);
    check("rst_t_vec", int'(t_vec), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    session(4'd5, 1'b1, 12);
    repeat (3) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
